// File: rtl/dmem_responder.sv
// Data-memory responder for the core's load/store port: one outstanding
// request, programmable wait latency, sign/zero-extended sub-word loads,
// lane-masked stores and an error response for illegal requests.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CW = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Word storage; never reset so the bench can preload it.
  logic [31:0] mem [0:DEPTH_WORDS-1];

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [2:0]    size_q, size_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          req_ready_d;
  logic          rsp_valid_d;
  logic [31:0]   rsp_rdata_d;
  logic          rsp_err_d;
  logic          mem_we_c;

  logic          err_c;
  logic [AW-1:0] idx_c;
  logic [31:0]   rd_word_c;
  logic [7:0]    byte_c;
  logic [15:0]   half_c;
  logic [31:0]   load_c;
  logic [31:0]   store_word_c;

  // Request legality check on the captured request.
  always_comb begin
    err_c = 1'b0;
    case (size_q)
      3'b011, 3'b110, 3'b111: err_c = 1'b1;
      default: ;
    endcase
    if (we_q && size_q[2]) err_c = 1'b1;
    if ((size_q[1:0] == 2'b01) && addr_q[0]) err_c = 1'b1;
    if ((size_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00)) err_c = 1'b1;
    if (32'(addr_q[31:2]) >= DEPTH_WORDS) err_c = 1'b1;
  end

  // Load lane extraction and store lane merge for the addressed word.
  always_comb begin
    idx_c     = addr_q[AW+1:2];
    rd_word_c = mem[idx_c];
    case (addr_q[1:0])
      2'd0:    byte_c = rd_word_c[7:0];
      2'd1:    byte_c = rd_word_c[15:8];
      2'd2:    byte_c = rd_word_c[23:16];
      default: byte_c = rd_word_c[31:24];
    endcase
    half_c = addr_q[1] ? rd_word_c[31:16] : rd_word_c[15:0];
    case (size_q)
      3'b000:  load_c = {{24{byte_c[7]}}, byte_c};
      3'b001:  load_c = {{16{half_c[15]}}, half_c};
      3'b010:  load_c = rd_word_c;
      3'b100:  load_c = {24'd0, byte_c};
      3'b101:  load_c = {16'd0, half_c};
      default: load_c = 32'd0;
    endcase
    store_word_c = rd_word_c;
    case (size_q[1:0])
      2'b00: begin
        case (addr_q[1:0])
          2'd0:    store_word_c[7:0]   = wdata_q[7:0];
          2'd1:    store_word_c[15:8]  = wdata_q[7:0];
          2'd2:    store_word_c[23:16] = wdata_q[7:0];
          default: store_word_c[31:24] = wdata_q[7:0];
        endcase
      end
      2'b01: begin
        if (addr_q[1]) store_word_c[31:16] = wdata_q[15:0];
        else           store_word_c[15:0]  = wdata_q[15:0];
      end
      2'b10:   store_word_c = wdata_q;
      default: ;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    size_d      = size_q;
    wdata_d     = wdata_q;
    req_ready_d = req_ready;
    rsp_valid_d = rsp_valid;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;
    mem_we_c    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          we_d        = req_we;
          addr_d      = req_addr;
          size_d      = req_size;
          wdata_d     = req_wdata;
          cnt_d       = CW'(LATENCY - 1);
          req_ready_d = 1'b0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          mem_we_c    = we_q && !err_c;
          rsp_valid_d = 1'b1;
          rsp_err_d   = err_c;
          rsp_rdata_d = (err_c || we_q) ? 32'd0 : load_c;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RESP: begin
        if (rsp_valid && rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_rdata_d = 32'd0;
          rsp_err_d   = 1'b0;
          req_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        rsp_rdata_d = 32'd0;
        rsp_err_d   = 1'b0;
        req_ready_d = 1'b1;
        cnt_d       = '0;
        state_d     = S_IDLE;
      end
    endcase
  end

  // State, captured request and response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= 32'd0;
      size_q    <= 3'd0;
      wdata_q   <= 32'd0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      wdata_q   <= wdata_d;
      req_ready <= req_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
    end
  end

  // Store commit on the access edge; a reset-aborted store never lands.
  always_ff @(posedge clk) begin
    if (mem_we_c && !reset) mem[idx_c] <= store_word_c;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: vector table replayed through a scoreboard queue,
// plus hand-written backpressure and mid-transaction reset sequences.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned LAT   = 2;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;
  localparam logic [2:0] SZ_X  = 3'b011;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [2:0]  req_size;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        chk_mem;
    int          mem_idx;
    logic [31:0] mem_exp;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] snap [DEPTH];

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_size  (req_size),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input logic we, input logic [2:0] sz,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] er, input logic e,
                              input int mi, input logic [31:0] me);
    vec_t v;
    v.name = n; v.we = we; v.size = sz; v.addr = a; v.wdata = wd;
    v.exp_rdata = er; v.exp_err = e;
    v.chk_mem = (mi >= 0); v.mem_idx = (mi >= 0) ? mi : 0; v.mem_exp = me;
    return v;
  endfunction

  // Issue one request, check latency and response, then the handshake if rsp_ready is high.
  task automatic run_txn(input vec_t v);
    int   lat;
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1; req_we = v.we; req_addr = v.addr;
    req_size = v.size; req_wdata = v.wdata;
    sb.push_back('{v.name, v.exp_rdata, v.exp_err});
    chk({v.name, ".ready_idle"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      chk({v.name, ".ready_wait"}, 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    chk({v.name, ".latency"}, 32'(lat), 32'(LAT));
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s.scoreboard: got empty queue expected one entry", v.name);
    end else begin
      e = sb.pop_front();
      chk({e.name, ".rdata"}, rsp_rdata, e.rdata);
      chk({e.name, ".err"}, 32'(rsp_err), 32'(e.err));
    end
    chk({v.name, ".ready_resp"}, 32'(req_ready), 32'd0);
    if (rsp_ready) begin
      @(posedge clk); #1;
      chk({v.name, ".hs_valid"}, 32'(rsp_valid), 32'd0);
      chk({v.name, ".hs_ready"}, 32'(req_ready), 32'd1);
      chk({v.name, ".hs_rdata"}, rsp_rdata, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int   diffs;
    int   seen;
    vec_t v;

    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0;
    req_size = 3'd0; req_wdata = 32'd0; rsp_ready = 1'b1;

    for (int i = 0; i < DEPTH; i++) dut.mem[i] = 32'd0;
    dut.mem[0]   = 32'h0000000A;
    dut.mem[2]   = 32'h80FF7F01;
    dut.mem[255] = 32'hCAFEF00D;

    vecs.push_back(mk("lw0",      1'b0, SZ_W,  32'h0,   32'h0,        32'h0000000A, 1'b0, -1, 32'h0));
    vecs.push_back(mk("sw4",      1'b1, SZ_W,  32'h4,   32'h00000006, 32'h0,        1'b0,  1, 32'h00000006));
    vecs.push_back(mk("lw4",      1'b0, SZ_W,  32'h4,   32'h0,        32'h00000006, 1'b0, -1, 32'h0));
    vecs.push_back(mk("lb9",      1'b0, SZ_B,  32'h9,   32'h0,        32'h0000007F, 1'b0, -1, 32'h0));
    vecs.push_back(mk("lbA",      1'b0, SZ_B,  32'hA,   32'h0,        32'hFFFFFFFF, 1'b0, -1, 32'h0));
    vecs.push_back(mk("lbuA",     1'b0, SZ_BU, 32'hA,   32'h0,        32'h000000FF, 1'b0, -1, 32'h0));
    vecs.push_back(mk("lhA",      1'b0, SZ_H,  32'hA,   32'h0,        32'hFFFF80FF, 1'b0, -1, 32'h0));
    vecs.push_back(mk("lhuA",     1'b0, SZ_HU, 32'hA,   32'h0,        32'h000080FF, 1'b0, -1, 32'h0));
    vecs.push_back(mk("sbB",      1'b1, SZ_B,  32'hB,   32'hAAAAAA55, 32'h0,        1'b0,  2, 32'h55FF7F01));
    vecs.push_back(mk("sh8",      1'b1, SZ_H,  32'h8,   32'hABCD1234, 32'h0,        1'b0,  2, 32'h55FF1234));
    vecs.push_back(mk("lw8",      1'b0, SZ_W,  32'h8,   32'h0,        32'h55FF1234, 1'b0, -1, 32'h0));
    vecs.push_back(mk("lw2_mis",  1'b0, SZ_W,  32'h2,   32'h0,        32'h0,        1'b1, -1, 32'h0));
    vecs.push_back(mk("sw400",    1'b1, SZ_W,  32'h400, 32'hDEADBEEF, 32'h0,        1'b1, -1, 32'h0));
    vecs.push_back(mk("size011",  1'b0, SZ_X,  32'h0,   32'h0,        32'h0,        1'b1, -1, 32'h0));
    vecs.push_back(mk("sb_sz100", 1'b1, SZ_BU, 32'h8,   32'h000000EE, 32'h0,        1'b1,  2, 32'h55FF1234));
    vecs.push_back(mk("lh9_mis",  1'b0, SZ_H,  32'h9,   32'h0,        32'h0,        1'b1, -1, 32'h0));
    vecs.push_back(mk("lw3FC",    1'b0, SZ_W,  32'h3FC, 32'h0,        32'hCAFEF00D, 1'b0, -1, 32'h0));

    #1;
    chk("reset.req_ready", 32'(req_ready), 32'd1);
    chk("reset.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset.rsp_rdata", rsp_rdata, 32'd0);
    chk("reset.rsp_err",   32'(rsp_err), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;

    foreach (vecs[i]) begin
      for (int j = 0; j < DEPTH; j++) snap[j] = dut.mem[j];
      run_txn(vecs[i]);
      if (vecs[i].chk_mem)
        chk({vecs[i].name, ".mem"}, dut.mem[vecs[i].mem_idx], vecs[i].mem_exp);
      if (vecs[i].exp_err) begin
        diffs = 0;
        for (int j = 0; j < DEPTH; j++) if (dut.mem[j] !== snap[j]) diffs++;
        chk({vecs[i].name, ".mem_unchanged"}, 32'(diffs), 32'd0);
      end
    end

    // Backpressure: response held for 5 cycles, a stray store request is ignored.
    rsp_ready = 1'b0;
    run_txn(mk("bp_lw0", 1'b0, SZ_W, 32'h0, 32'h0, 32'h0000000A, 1'b0, -1, 32'h0));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 2) begin
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0;
        req_size = SZ_W; req_wdata = 32'h00000BAD;
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("bp.rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp.rsp_rdata", rsp_rdata, 32'h0000000A);
      chk("bp.rsp_err",   32'(rsp_err), 32'd0);
      chk("bp.req_ready", 32'(req_ready), 32'd0);
    end
    @(negedge clk) rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp.hs_valid", 32'(rsp_valid), 32'd0);
    chk("bp.hs_ready", 32'(req_ready), 32'd1);
    seen = 0;
    repeat (2 * LAT + 4) begin
      @(posedge clk); #1;
      if (rsp_valid) seen++;
    end
    chk("bp.no_ghost_rsp", 32'(seen), 32'd0);
    chk("bp.mem0", dut.mem[0], 32'h0000000A);

    // Reset during WAIT: store must not commit, outputs clear without an edge.
    dut.mem[3] = 32'd0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'hC;
    req_size = SZ_W; req_wdata = 32'h11111111;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst_wait.in_wait", 32'(req_ready), 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("rst_wait.req_ready", 32'(req_ready), 32'd1);
    chk("rst_wait.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_wait.rsp_err",   32'(rsp_err), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    chk("rst_wait.mem3", dut.mem[3], 32'd0);
    run_txn(mk("rst_lwC", 1'b0, SZ_W, 32'hC, 32'h0, 32'h0, 1'b0, -1, 32'h0));

    // Reset during RESP: held response clears without an edge.
    rsp_ready = 1'b0;
    run_txn(mk("rr_lw8", 1'b0, SZ_W, 32'h8, 32'h0, 32'h55FF1234, 1'b0, -1, 32'h0));
    #2 reset = 1'b1;
    #1;
    chk("rst_resp.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_resp.rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_resp.req_ready", 32'(req_ready), 32'd1);
    @(negedge clk) reset = 1'b0;
    rsp_ready = 1'b1;
    run_txn(mk("rr_lw3FC", 1'b0, SZ_W, 32'h3FC, 32'h0, 32'hCAFEF00D, 1'b0, -1, 32'h0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined RISC-V core's load/store port. It accepts one request at a time through a valid/ready handshake and services it after a programmable number of wait cycles. Loads return sign- or zero-extended byte, half or word data; stores are byte-lane masked. Misaligned, out-of-range and illegal-size requests produce an error response. The block replaces the zero-latency data array so the pipeline's memory-stall path can be exercised, and it doubles as a bench memory model.

## Interface
Parameters:
- DEPTH_WORDS, 256: number of 32-bit words in storage. Byte range is 0 .. 4*DEPTH_WORDS-1.
- LATENCY, 2: wait edges from request accept to response valid. Legal range is 1..15.

Ports:
- clk  in  1  clock. All state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_size  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  32  load result. 0 for stores and for errors.
- rsp_err  out  1  the request was rejected.

## Operation
- Storage is the word array mem[0:DEPTH_WORDS-1]. It is not cleared by reset and can be backdoor-loaded by the bench.
- The FSM has three states: IDLE, WAIT and RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, capture we, addr, size and wdata. Load the wait counter with LATENCY-1 and go to WAIT.
- WAIT:
  - req_ready=0.
  - Decrement the counter each edge.
  - On the edge where the counter is 0, perform the access, register rsp_rdata and rsp_err, and go to RESP.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable.
  - On rsp_valid&&rsp_ready, go to IDLE and clear rsp_valid, rsp_rdata and rsp_err.
- Error conditions, evaluated on the captured request:
  - size is 011, 110 or 111;
  - a store with size[2]=1;
  - H/HU with addr[0]≠0;
  - W with addr[1:0]≠0;
  - addr[31:2] ≥ DEPTH_WORDS.
- On error: no write, rsp_rdata=0, rsp_err=1. Timing is identical to a good access.
- Load extraction:
  - Word index is addr[31:2].
  - Byte lane is addr[1:0]; half lane is addr[1].
  - B/H sign-extend; BU/HU zero-extend.
- Store: only the addressed lanes are written, using wdata[7:0] for B and wdata[15:0] for H. All other bytes are unchanged.
- A store still returns one response (rdata=0, err as evaluated).
- Request inputs are ignored outside IDLE. No queueing.

## Timing
- Reset values: FSM=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
- Reset asserted mid-WAIT or mid-RESP:
  - the transaction is dropped and any uncommitted store never commits;
  - the outputs return to their reset values immediately, without waiting for a clock edge.
- Accept edge is N. The memory access happens on edge N+LATENCY, and rsp_valid=1 from that edge onward.
- With rsp_ready=1 held, the response handshakes on edge N+LATENCY+1 and req_ready=1 again after it.
- The next accept is at the earliest edge N+LATENCY+2, giving a minimum request spacing of LATENCY+2 cycles.
- While rsp_ready=0, RESP holds indefinitely with all outputs stable.
- A store to address A followed by a load from A returns the new data. The store has fully committed before its response.
- LATENCY=1: WAIT lasts exactly one edge, so the counter starts at 0.

## Test plan
- Read latency: backdoor mem[0]=0x0000000A, LATENCY=2. LW addr 0x0 accepted at edge N → rsp_valid at N+2 with rdata=0x0000000A, err=0. req_ready=0 in the cycles after N until the handshake.
- Write then read: SW 0x00000006 to 0x4, then LW 0x4 → mem[1]=0x00000006 and rdata=0x00000006.
- Sub-word loads and store, with mem[2]=0x80FF7F01:
  - LB 0x9 → 0x0000007F.
  - LB 0xA → 0xFFFFFFFF.
  - LBU 0xA → 0x000000FF.
  - LH 0xA → 0xFFFF80FF.
  - LHU 0xA → 0x000080FF.
  - SB 0x55 to 0xB → mem[2]=0x55FF7F01.
  - SH 0x1234 to 0x8 → mem[2]=0x55FF1234.
- Errors:
  - LW 0x2 → err=1, rdata=0.
  - SW 0xDEADBEEF to 0x400 (DEPTH_WORDS=256) → err=1, no word of mem changes.
  - size 011 → err=1.
  - SB with size 100 → err=1, mem unchanged.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid rises → rsp_valid, rsp_rdata and rsp_err stay stable and req_ready stays 0. A second req_valid pulse is ignored. Raising rsp_ready → one handshake, then IDLE.
- Reset mid-operation: SW 0x11111111 to 0xC with mem[3]=0, assert reset during WAIT → mem[3] stays 0. Outputs go to their reset values without a clock edge. A subsequent LW 0xC returns 0.
